// File: rtl/vga_timing_generator_if.sv
// Pixel-side bundle of the VGA timing generator: the pixel tick and colour
// going in, raster position, sync, blanking and frame/line markers coming out.
interface vga_timing_generator_if #(
  parameter int CNT_W = 10,
  parameter int RGB_W = 3
);

  logic             iEnable;
  logic [RGB_W-1:0] iRGB;
  logic [CNT_W-1:0] oHcounter;
  logic [CNT_W-1:0] oVcounter;
  logic             oHsync;
  logic             oVsync;
  logic             oActive;
  logic [RGB_W-1:0] oVGA_RGB;
  logic             oLineEnd;
  logic             oFrameStart;

  // Pixel source / display side: drives the tick and colour, consumes timing.
  modport master (
    output iEnable,
    output iRGB,
    input  oHcounter,
    input  oVcounter,
    input  oHsync,
    input  oVsync,
    input  oActive,
    input  oVGA_RGB,
    input  oLineEnd,
    input  oFrameStart
  );

  // Timing generator side.
  modport slave (
    input  iEnable,
    input  iRGB,
    output oHcounter,
    output oVcounter,
    output oHsync,
    output oVsync,
    output oActive,
    output oVGA_RGB,
    output oLineEnd,
    output oFrameStart
  );

endinterface

// File: rtl/vga_timing_generator.sv
// VGA raster timing generator.
// Two free-running counters walk the raster one pixel per enabled tick.
// Sync, visible-region flag, blanked colour and the line/frame markers are
// all registered from the pre-edge counter values, so they trail the
// counters by exactly one enabled tick and iRGB never reaches an output
// without passing through a flop.
module vga_timing_generator #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 10,
  parameter int RGB_W    = 3
) (
  input logic                   Clock,
  input logic                   Reset,
  vga_timing_generator_if.slave vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Sync windows as inclusive [start, stop] pixel/line positions. A zero
  // sync width gives stop < start, i.e. an empty window.
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_STOP  = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_STOP  = V_ACTIVE + V_FP + V_SYNC - 1;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  // A raster that cannot be addressed by the counters is a configuration
  // error, not something to silently wrap.
  generate
    if ((CNT_W < 1) || (CNT_W > 30)) begin : g_bad_cnt_w
      $error("vga_timing_generator: CNT_W=%0d outside 1..30", CNT_W);
    end
    if ((H_TOTAL < 1) || (longint'(H_TOTAL) > (longint'(1) << CNT_W))) begin : g_bad_h_total
      $error("vga_timing_generator: H_TOTAL=%0d does not fit CNT_W=%0d", H_TOTAL, CNT_W);
    end
    if ((V_TOTAL < 1) || (longint'(V_TOTAL) > (longint'(1) << CNT_W))) begin : g_bad_v_total
      $error("vga_timing_generator: V_TOTAL=%0d does not fit CNT_W=%0d", V_TOTAL, CNT_W);
    end
    if (RGB_W < 1) begin : g_bad_rgb_w
      $error("vga_timing_generator: RGB_W=%0d must be at least 1", RGB_W);
    end
  endgenerate

  // Unsigned position test against an inclusive window; the counter is
  // zero-extended so the comparison is purely unsigned.
  function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                     input int lo, input int hi);
    int p;
    p = int'(pos);
    return (p >= lo) && (p <= hi);
  endfunction

  // Unsigned "below limit" test used for the visible region.
  function automatic logic below(input logic [CNT_W-1:0] pos, input int lim);
    return int'(pos) < lim;
  endfunction

  // Sync level for a given window hit at the configured polarity.
  function automatic logic sync_level(input logic hit, input logic pol);
    return hit ? pol : ~pol;
  endfunction

  // Colour gate: blank outside the visible region.
  function automatic logic [RGB_W-1:0] blank_rgb(input logic vis,
                                                 input logic [RGB_W-1:0] rgb);
    return vis ? rgb : '0;
  endfunction

  logic             en;
  logic [RGB_W-1:0] rgb_in;

  assign en     = vga.iEnable;
  assign rgb_in = vga.iRGB;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic             h_wrap;
  logic             v_wrap;
  logic             at_origin;

  // Decode of the pre-edge raster position feeding the output stage.
  logic             hs_hit;
  logic             vs_hit;
  logic             vis;

  // ---- stage p0: raster position decode ----
  assign h_wrap    = (h_cnt == H_LAST);
  assign v_wrap    = (v_cnt == V_LAST);
  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign hs_hit    = in_window(h_cnt, HS_START, HS_STOP);
  assign vs_hit    = in_window(v_cnt, VS_START, VS_STOP);
  assign vis       = below(h_cnt, H_ACTIVE) && below(v_cnt, V_ACTIVE);

  // Next raster position: pixel wraps at end of line, line advances only on
  // the last pixel and wraps at end of frame on that same tick.
  always_comb begin
    h_next = h_cnt;
    v_next = v_cnt;
    if (h_wrap) begin
      h_next = '0;
      v_next = v_wrap ? '0 : (v_cnt + ONE);
    end else begin
      h_next = h_cnt + ONE;
    end
  end

  // Raster counters advance once per enabled tick.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      h_cnt <= h_next;
      v_cnt <= v_next;
    end
  end

  // ---- stage p1: registered timing outputs ----
  logic             hsync_p1;
  logic             vsync_p1;
  logic             active_p1;
  logic [RGB_W-1:0] rgb_p1;
  logic             line_end_p1;
  logic             frame_start_p1;

  // Sync, visible flag and blanked colour are loaded on enabled ticks and
  // hold otherwise, so they stay aligned with the counters they trail.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      hsync_p1  <= ~HS_POL;
      vsync_p1  <= ~VS_POL;
      active_p1 <= 1'b0;
      rgb_p1    <= '0;
    end else if (en) begin
      hsync_p1  <= sync_level(hs_hit, HS_POL);
      vsync_p1  <= sync_level(vs_hit, VS_POL);
      active_p1 <= vis;
      rgb_p1    <= blank_rgb(vis, rgb_in);
    end
  end

  // Line/frame markers are single-Clock pulses: they clear on any cycle that
  // is not an enabled tick at the marked position, so gaps in iEnable never
  // stretch them.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      line_end_p1    <= 1'b0;
      frame_start_p1 <= 1'b0;
    end else begin
      line_end_p1    <= en && h_wrap;
      frame_start_p1 <= en && at_origin;
    end
  end

  assign vga.oHcounter   = h_cnt;
  assign vga.oVcounter   = v_cnt;
  assign vga.oHsync      = hsync_p1;
  assign vga.oVsync      = vsync_p1;
  assign vga.oActive     = active_p1;
  assign vga.oVGA_RGB    = rgb_p1;
  assign vga.oLineEnd    = line_end_p1;
  assign vga.oFrameStart = frame_start_p1;

endmodule

// File: doc/vga_timing_generator.md
VGA_TIMING_GENERATOR -- requirements
Module: vga_timing_generator

Interface
REQ-001 The parameter list SHALL be as follows, one per line as name, default, meaning:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HS_POL, 0, asserted level of oHsync
- VS_POL, 0, asserted level of oVsync
- CNT_W, 10, counter width
- RGB_W, 3, colour bus width
REQ-002 The port list SHALL be as follows, one per line as name, direction, width, meaning:
- Clock, in, 1, single clock; all state on rising edge
- Reset, in, 1, asynchronous, active-low reset
- iEnable, in, 1, pixel tick; state advances only when high
- iRGB, in, RGB_W, pixel colour for current oHcounter/oVcounter
- oHcounter, out, CNT_W, current horizontal position
- oVcounter, out, CNT_W, current vertical position
- oHsync, out, 1, horizontal sync, polarity HS_POL
- oVsync, out, 1, vertical sync, polarity VS_POL
- oActive, out, 1, pipelined visible-region flag
- oVGA_RGB, out, RGB_W, pipelined, blanked colour
- oLineEnd, out, 1, one-Clock pulse at last pixel of a line
- oFrameStart, out, 1, one-Clock pulse at pixel (0,0)

Function
REQ-003 The design SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL as the analogous vertical sum; defaults give 800 and 525.
REQ-004 On a Clock edge with iEnable=1, oHcounter SHALL increment, and SHALL wrap from H_TOTAL-1 to 0.
REQ-005 oVcounter SHALL increment only on an enabled edge where oHcounter=H_TOTAL-1, and SHALL wrap from V_TOTAL-1 to 0 on that same edge.
REQ-006 With iEnable=0, the counters and all registered outputs SHALL hold, except that oLineEnd and oFrameStart SHALL be 0.
REQ-007 Sync, active and colour outputs SHALL be registered, lagging the counters by exactly one enabled tick; each is computed from the pre-edge counter values (H,V) and iRGB.
REQ-008 On each enabled edge, oHsync SHALL be loaded with HS_POL when H_ACTIVE+H_FP <= H <= H_ACTIVE+H_FP+H_SYNC-1, and with ~HS_POL otherwise.
REQ-009 On each enabled edge, oVsync SHALL be loaded with VS_POL when V_ACTIVE+V_FP <= V <= V_ACTIVE+V_FP+V_SYNC-1, and with ~VS_POL otherwise; the vertical test SHALL use the pre-edge V.
REQ-010 On each enabled edge, oActive SHALL be loaded with (H<H_ACTIVE && V<V_ACTIVE).
REQ-011 On each enabled edge, oVGA_RGB SHALL be loaded with iRGB when that active condition holds, and with all-zero otherwise; there SHALL be no combinational path from iRGB to any output.
REQ-012 oLineEnd SHALL be 1 for the one Clock cycle following an enabled edge with H=H_TOTAL-1, and 0 otherwise.
REQ-013 oFrameStart SHALL be 1 for the one Clock cycle following an enabled edge with H=0 and V=0, and 0 otherwise.
REQ-014 All comparisons SHALL be unsigned at CNT_W bits.
REQ-015 H_TOTAL and V_TOTAL SHALL be at most 2^CNT_W; a violating parameter set is illegal and SHALL be rejected at elaboration.

Reset
REQ-016 Reset=0 SHALL immediately, without waiting for a Clock edge, force:
- oHcounter=0 and oVcounter=0
- oHsync=~HS_POL and oVsync=~VS_POL
- oActive=0 and oVGA_RGB=0
- oLineEnd=0 and oFrameStart=0
REQ-017 An assertion of Reset in mid-frame SHALL abort the frame; after deassertion, the first enabled edge SHALL start a new frame from (0,0) and SHALL pulse oFrameStart.
REQ-018 Deassertion of Reset SHALL be assumed synchronous to Clock, with the synchroniser external to this block.

Verification
REQ-019 Free-run check, defaults, iEnable=1: over 420000 edges, oHcounter SHALL wrap every 800 cycles and oVcounter every 525 lines; oFrameStart SHALL pulse every 420000 cycles; oLineEnd SHALL pulse every 800 cycles.
REQ-020 Sync timing check, defaults: oHsync SHALL be 0 for exactly 96 enabled ticks per line, first low one tick after H=656; oVsync SHALL be 0 for exactly 2 lines per frame, covering V=490..491 delayed by one tick.
REQ-021 Blanking check: iRGB=3'b111 held constant SHALL give oVGA_RGB=3'b111 on exactly 640x480 ticks per frame and 3'b000 on all others, with oActive matching.
REQ-022 Enable gating check: iEnable toggling 1,0,1,0 SHALL cause the counters to advance once per two Clocks; every output sequence SHALL equal the iEnable=1 run stretched by 2x, with pulses one Clock wide.
REQ-023 Asynchronous reset check: Reset=0 asserted at H=300, V=200, between Clock edges, SHALL take all outputs to their reset values before the next edge; after release, the first enabled edge SHALL produce oFrameStart=1.
REQ-024 Parameter check: H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, HS_POL=1, VS_POL=1, CNT_W=4 SHALL give H_TOTAL=12, V_TOTAL=7, oHsync high for H=9..10 delayed one tick, and oVsync high for V=5.
